// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg -- shared definitions for the 7-segment display blocks.
//
// Contents:
//   seg_state_e    scan controller FSM encoding (IDLE, LOAD, DRIVE, DEAD)
//   digit_t        one display digit: {value[3:0], dp, blank}
//   NUM_DIGITS     number of multiplexed digits
//   HEX_SEG_TABLE  16-entry nibble -> segment table, bit0=a .. bit6=g
//   digit_sel_n()  active-low one-cold digit select for an index
// ----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DEAD  = 2'd3
  } seg_state_e;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam int NUM_DIGITS = 4;

  // Entry n is the segment pattern for nibble n; entry 15 is listed first
  // because this is a packed concatenation.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Digit k is selected by driving bit k low.
  function automatic logic [3:0] digit_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg -- combinational hex nibble to 7-segment decoder.
//
// Ports:
//   nibble_i [3:0]  hex digit to show
//   seg_o    [6:0]  active-high segments, bit0=a .. bit6=g
// ----------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl -- 4-digit multiplexed 7-segment scan controller.
//
// A shadow bank is written through a valid/ready port; the displayed
// (active) bank is refreshed from it once per frame in the LOAD state so a
// frame never mixes old and new digit values. Each digit is driven for
// DWELL_CYCLES, followed by DEAD_CYCLES of all-off to avoid ghosting.
//
// Parameters:
//   DWELL_CYCLES  cycles each digit is driven (must be >= 1)
//   DEAD_CYCLES   all-off cycles after each digit (0 skips the DEAD state)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        scanning runs while high; low returns to IDLE
//   wr_valid      write request
//   wr_ready      write can be accepted (low only in LOAD and in reset)
//   wr_digit      target digit 0..3
//   wr_value      hex nibble
//   wr_dp         decimal point
//   wr_blank      force digit dark
//   segment[7:0]  active-high segments, bit7 = dp
//   segsel[3:0]   active-low digit select
//   frame_tick    one-cycle pulse on the last cycle of a full frame
//   dbg_state     current FSM state
// ----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000,
  parameter int DEAD_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       wr_blank,
  output logic [7:0] segment,
  output logic [3:0] segsel,
  output logic       frame_tick,
  output seg_state_e dbg_state
);

  // Handshake: a write is taken on every rising edge where wr_valid and
  // wr_ready are both high. The writer holds its request (and its data)
  // until that edge; wr_ready does not depend on wr_valid.

  localparam int MAX_CYC = (DWELL_CYCLES > DEAD_CYCLES) ? DWELL_CYCLES : DEAD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seg_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;

  digit_t [NUM_DIGITS-1:0] shadow_q;
  digit_t [NUM_DIGITS-1:0] active_q, active_d;

  logic [7:0] segment_q, segment_d;
  logic [3:0] segsel_q,  segsel_d;
  logic       tick_q,    tick_d;
  logic       ready_q,   ready_d;

  logic       wr_fire;
  digit_t     cur_digit;
  logic [6:0] hex_seg;

  assign wr_fire = wr_valid & ready_q;

  // The active bank takes the shadow contents on the edge that leaves LOAD.
  assign active_d = (state_q == ST_LOAD) ? shadow_q : active_q;

  // --------------------------------------------------------------------------
  // State register (also holds the registered outputs and both banks)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      segment_q <= 8'h00;
      segsel_q  <= 4'hF;
      tick_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      segment_q <= segment_d;
      segsel_q  <= segsel_d;
      tick_q    <= tick_d;
      ready_q   <= ready_d;
      if (wr_fire) begin
        shadow_q[wr_digit] <= '{value: wr_value, dp: wr_dp, blank: wr_blank};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (HAS_DEAD) begin
              state_d = ST_DEAD;
            end else if (idx_q == 2'd3) begin
              state_d = ST_LOAD;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            cnt_d = '0;
            if (idx_q == 2'd3) begin
              state_d = ST_LOAD;
              idx_d   = '0;
            end else begin
              state_d = ST_DRIVE;
              idx_d   = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: computed from the next state so the registered outputs
  // line up with the state they describe.
  // --------------------------------------------------------------------------
  assign cur_digit = active_d[idx_d];

  hex7seg u_hex7seg (
    .nibble_i (cur_digit.value),
    .seg_o    (hex_seg)
  );

  always_comb begin
    segment_d = 8'h00;
    segsel_d  = 4'hF;
    tick_d    = 1'b0;
    ready_d   = (state_d != ST_LOAD);
    if (state_d == ST_DRIVE) begin
      segsel_d = digit_sel_n(idx_d);
      if (!cur_digit.blank) begin
        segment_d = {cur_digit.dp, hex_seg};
      end
    end
    // The frame ends on the last dark cycle of digit 3, or on its last
    // driven cycle when there is no dead time.
    if (HAS_DEAD) begin
      tick_d = (state_d == ST_DEAD) && (idx_d == 2'd3) && (cnt_d == DEAD_LAST);
    end else begin
      tick_d = (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == DWELL_LAST);
    end
  end

  assign segment    = segment_q;
  assign segsel     = segsel_q;
  assign frame_tick = tick_q;
  assign wr_ready   = ready_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl -- bench for seg_scan_ctrl with DWELL_CYCLES=4,
// DEAD_CYCLES=2. A reference model describes each cycle by its position in
// the frame (LOAD, then four digit slots of dwell+dead cycles) and pushes the
// expected outputs into exp_q; a monitor pops and compares on every falling
// edge while the block is out of reset.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int DW    = 4;
  localparam int DD    = 2;
  localparam int SPAN  = DW + DD;
  localparam int FRAME = 1 + 4 * SPAN;
  localparam int EW    = 14;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_digit = 2'd0;
  logic [3:0] wr_value = 4'd0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic       wr_ready;
  logic [7:0] segment;
  logic [3:0] segsel;
  logic       frame_tick;
  seg_state_e dbg_state;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .DEAD_CYCLES  (DD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digit   (wr_digit),
    .wr_value   (wr_value),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .segment    (segment),
    .segsel     (segsel),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] pack_out(input logic [3:0] ss, input logic [7:0] sg,
                                             input logic rdy, input logic tk);
    return {ss, sg, rdy, tk};
  endfunction

  task automatic check_out(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @%0t: got segsel=%h segment=%h ready=%b tick=%b, expected segsel=%h segment=%h ready=%b tick=%b",
                  name, $time, act[13:10], act[9:2], act[1], act[0], exp[13:10], exp[9:2], exp[1], exp[0]);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [6:0] hex_ref [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] sh_val [4];
  logic       sh_dp  [4];
  logic       sh_bl  [4];
  logic [3:0] ac_val [4];
  logic       ac_dp  [4];
  logic       ac_bl  [4];
  int         run_t = -1;     // cycles since the frame's LOAD; -1 when idle
  logic       prev_ready = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sh_val[i] = 4'd0; sh_dp[i] = 1'b0; sh_bl[i] = 1'b0;
        ac_val[i] = 4'd0; ac_dp[i] = 1'b0; ac_bl[i] = 1'b0;
      end
      run_t      = -1;
      prev_ready = 1'b0;
    end else begin
      logic [3:0] ss;
      logic [7:0] sg;
      logic       rdy;
      logic       tk;
      int         q, d, r;
      if (prev_ready && wr_valid) begin
        sh_val[wr_digit] = wr_value;
        sh_dp[wr_digit]  = wr_dp;
        sh_bl[wr_digit]  = wr_blank;
      end
      if (run_t == 0) begin
        for (int i = 0; i < 4; i++) begin
          ac_val[i] = sh_val[i]; ac_dp[i] = sh_dp[i]; ac_bl[i] = sh_bl[i];
        end
      end
      if (!enable)        run_t = -1;
      else if (run_t < 0) run_t = 0;
      else                run_t = (run_t + 1) % FRAME;

      ss = 4'hF; sg = 8'h00; rdy = 1'b1; tk = 1'b0;
      if (run_t == 0) begin
        rdy = 1'b0;
      end else if (run_t > 0) begin
        q = run_t - 1;
        d = q / SPAN;
        r = q % SPAN;
        if (r < DW) begin
          ss[d] = 1'b0;
          sg = ac_bl[d] ? 8'h00 : {ac_dp[d], hex_ref[ac_val[d]]};
        end
        tk = (d == 3) && (r == SPAN - 1);
      end
      prev_ready = rdy;
      exp_q.push_back(pack_out(ss, sg, rdy, tk));
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check_out("reset_outputs", pack_out(segsel, segment, wr_ready, frame_tick),
                pack_out(4'hF, 8'h00, 1'b0, 1'b0));
      check_val("reset_state", int'(dbg_state), int'(ST_IDLE));
    end else if (exp_q.size() > 0) begin
      check_out("scan", pack_out(segsel, segment, wr_ready, frame_tick), exp_q.pop_front());
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // --------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_digit(input logic [1:0] d, input logic [3:0] v, input logic dp, input logic bl);
    logic r;
    bit   acc;
    acc      = 1'b0;
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    wr_dp    = dp;
    wr_blank = bl;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      r = wr_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    wr_valid = 1'b0;
    check_val("write_accept", int'(acc), 1);
  endtask

  // Returns at a falling edge where segsel matches (or, with differ set,
  // does not match) the given pattern.
  task automatic wait_segsel(input logic [3:0] pat, input bit differ);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 4 * FRAME; t++) begin
      @(negedge clk);
      if ((segsel == pat) != differ) begin
        found = 1'b1;
        break;
      end
    end
    check_val("wait_segsel", int'(found), 1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(3);

    // Default contents: "0000" scanned.
    enable = 1'b1;
    wait_cycles(2 * FRAME);

    // 1, 2, 3., A
    write_digit(2'd0, 4'h1, 1'b0, 1'b0);
    write_digit(2'd1, 4'h2, 1'b0, 1'b0);
    write_digit(2'd2, 4'h3, 1'b1, 1'b0);
    write_digit(2'd3, 4'hA, 1'b0, 1'b0);
    wait_cycles(2 * FRAME);

    // Mid-frame update of digit 1.
    wait_segsel(4'b1110, 1'b0);
    @(posedge clk); #1;
    write_digit(2'd1, 4'h7, 1'b0, 1'b0);
    wait_cycles(2 * FRAME);

    // Blank digit 3.
    write_digit(2'd3, 4'h8, 1'b1, 1'b1);
    wait_cycles(2 * FRAME);

    // Drop enable while digit 2 is driven, then restart.
    wait_segsel(4'b1011, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_cycles(3);
    enable = 1'b1;
    wait_cycles(FRAME + 3);

    // Randomized writes and enable drops.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        wait_cycles($urandom_range(1, 3));
        enable = 1'b1;
      end
      if ($urandom_range(0, 2) != 0) begin
        write_digit(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end
      wait_cycles($urandom_range(0, 8));
    end
    enable = 1'b1;
    wait_cycles(2 * FRAME);

    // Asynchronous reset in the middle of a driven digit.
    wait_segsel(4'hF, 1'b1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_out("async_reset", pack_out(segsel, segment, wr_ready, frame_tick),
              pack_out(4'hF, 8'h00, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2 * FRAME);

    enable = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    #1;
    check_val("queue_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
